// File: rtl/lwc_pipe_reg_pkg.sv
// Shared helpers for the LWC elastic register pipeline.
package lwc_pipe_reg_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lwc_pipe_reg_stage.sv
// One elastic pipeline stage: valid bit plus data word.
module lwc_pipe_reg_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          RST_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Flush drops words but leaves data untouched; rst wins over flush.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (rst_i) begin
            v_d = 1'b0;
            if (RST_DATA) d_d = '0;
        end else if (flush_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d = 1'b1;
            d_d = din_i;
        end else if (adv_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        v_q <= v_d;
        d_q <= d_d;
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/lwc_pipe_reg.sv
// Elastic DEPTH-stage register pipeline with flush and occupancy count.
module lwc_pipe_reg
    import lwc_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter bit          RST_DATA = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WIDTH-1:0]          m_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign m_valid  = v[DEPTH-1] & ~flush & ~rst;
    assign out_xfer = m_valid & m_ready;

    // Ready ripples from m_ready back to the input through every stage.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_xfer;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
    end

    assign s_ready = ~rst & ~flush & (~v[0] | adv[0]);
    assign in_xfer = s_valid & s_ready;

    always_comb begin
        load    = '0;
        load[0] = in_xfer;
        for (int k = 1; k < int'(DEPTH); k++) begin
            load[k] = adv[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] din;
        if (k == 0) begin : g_first
            assign din = s_data;
        end else begin : g_rest
            assign din = d[k-1];
        end

        lwc_pipe_reg_stage #(
            .WIDTH    (WIDTH),
            .RST_DATA (RST_DATA)
        ) u_stage (
            .clk     (clk),
            .rst_i   (rst),
            .flush_i (flush),
            .load_i  (load[k]),
            .adv_i   (adv[k]),
            .din_i   (din),
            .valid_o (v[k]),
            .data_o  (d[k])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rst || flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign m_data = d[DEPTH-1];
    assign count  = cnt_q;

endmodule

// File: tb/tb_lwc_pipe_reg.sv
// Directed bench for lwc_pipe_reg: DEPTH=4/WIDTH=32 and DEPTH=1/WIDTH=8.
module tb_lwc_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    logic        a_s_valid = 1'b0;
    logic        a_s_ready;
    logic [31:0] a_s_data = '0;
    logic        a_m_valid;
    logic        a_m_ready = 1'b0;
    logic [31:0] a_m_data;
    logic [2:0]  a_count;

    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic [7:0]  b_s_data = '0;
    logic        b_m_valid;
    logic        b_m_ready = 1'b0;
    logic [7:0]  b_m_data;
    logic [0:0]  b_count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lwc_pipe_reg #(.WIDTH(32), .DEPTH(4), .RST_DATA(1'b1)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count)
    );

    lwc_pipe_reg #(.WIDTH(8), .DEPTH(1), .RST_DATA(1'b1)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        #1;
        nvec++; if (a_s_ready !== 1'b0) begin nerr++; $display("FAIL rst_sready got %b want 0", a_s_ready); end
        nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL rst_mvalid got %b want 0", a_m_valid); end
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d want 0", a_count); end
        nvec++; if (a_m_data !== 32'h0) begin nerr++; $display("FAIL rst_mdata got %h want 0", a_m_data); end
        nvec++; if (b_m_valid !== 1'b0) begin nerr++; $display("FAIL rst_b_mvalid got %b want 0", b_m_valid); end
        nvec++; if (b_count !== 1'b0) begin nerr++; $display("FAIL rst_b_count got %0d want 0", b_count); end
        rst = 1'b0;
        #1;
        nvec++; if (a_s_ready !== 1'b1) begin nerr++; $display("FAIL rel_sready got %b want 1", a_s_ready); end
        nvec++; if (b_s_ready !== 1'b1) begin nerr++; $display("FAIL rel_b_sready got %b want 1", b_s_ready); end
        tick();
    endtask

    task automatic test_stream;
        int exp_cnt;
        bit exp_v;
        a_m_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            a_s_valid = (c < 16);
            a_s_data  = 32'(c + 1);
            #1;
            exp_v   = (c >= 4) && (c < 20);
            exp_cnt = ((c < 16) ? c : 16) - ((c > 4) ? (((c - 4) < 16) ? (c - 4) : 16) : 0);
            nvec++; if (a_s_ready !== 1'b1) begin nerr++; $display("FAIL stream_sready c=%0d got %b want 1", c, a_s_ready); end
            nvec++; if (a_m_valid !== exp_v) begin nerr++; $display("FAIL stream_mvalid c=%0d got %b want %b", c, a_m_valid, exp_v); end
            nvec++; if (a_count !== 3'(exp_cnt)) begin nerr++; $display("FAIL stream_count c=%0d got %0d want %0d", c, a_count, exp_cnt); end
            if (exp_v) begin
                nvec++; if (a_m_data !== 32'(c - 3)) begin nerr++; $display("FAIL stream_mdata c=%0d got %h want %h", c, a_m_data, 32'(c - 3)); end
            end
            tick();
        end
        a_s_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [31:0] w [5];
        w[0] = 32'hAAAA_0001;
        w[1] = 32'hBBBB_0002;
        w[2] = 32'hCCCC_0003;
        w[3] = 32'hDDDD_0004;
        w[4] = 32'hEEEE_0005;
        a_m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = w[i];
            #1;
            nvec++; if (a_s_ready !== 1'b1) begin nerr++; $display("FAIL bp_fill_sready i=%0d got %b want 1", i, a_s_ready); end
            tick();
        end
        a_s_data = w[4];
        for (int h = 0; h < 2; h++) begin
            #1;
            nvec++; if (a_s_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_sready h=%0d got %b want 0", h, a_s_ready); end
            nvec++; if (a_count !== 3'd4) begin nerr++; $display("FAIL bp_full_count h=%0d got %0d want 4", h, a_count); end
            nvec++; if (a_m_valid !== 1'b1) begin nerr++; $display("FAIL bp_full_mvalid h=%0d got %b want 1", h, a_m_valid); end
            nvec++; if (a_m_data !== w[0]) begin nerr++; $display("FAIL bp_full_mdata h=%0d got %h want %h", h, a_m_data, w[0]); end
            tick();
        end
        a_m_ready = 1'b1;
        #1;
        nvec++; if (a_s_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_sready got %b want 1", a_s_ready); end
        for (int i = 0; i < 5; i++) begin
            nvec++; if (a_m_valid !== 1'b1) begin nerr++; $display("FAIL bp_drain_mvalid i=%0d got %b want 1", i, a_m_valid); end
            nvec++; if (a_m_data !== w[i]) begin nerr++; $display("FAIL bp_drain_mdata i=%0d got %h want %h", i, a_m_data, w[i]); end
            nvec++; if (a_count !== 3'((i == 0) ? 4 : 5 - i)) begin nerr++; $display("FAIL bp_drain_count i=%0d got %0d want %0d", i, a_count, (i == 0) ? 4 : 5 - i); end
            tick();
            a_s_valid = 1'b0;
            #1;
        end
        nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL bp_empty_mvalid got %b want 0", a_m_valid); end
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL bp_empty_count got %0d want 0", a_count); end
        tick();
    endtask

    task automatic test_bubble;
        a_m_ready = 1'b0;
        a_s_valid = 1'b1;
        a_s_data  = 32'h1234_5678;
        tick();
        a_s_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            nvec++; if (a_m_valid !== (c == 4)) begin nerr++; $display("FAIL bubble_mvalid c=%0d got %b want %b", c, a_m_valid, c == 4); end
            nvec++; if (a_s_ready !== 1'b1) begin nerr++; $display("FAIL bubble_sready c=%0d got %b want 1", c, a_s_ready); end
            nvec++; if (a_count !== 3'd1) begin nerr++; $display("FAIL bubble_count c=%0d got %0d want 1", c, a_count); end
            if (c == 4) begin
                nvec++; if (a_m_data !== 32'h1234_5678) begin nerr++; $display("FAIL bubble_mdata got %h want 12345678", a_m_data); end
            end
            tick();
        end
        a_m_ready = 1'b1;
        tick();
        #1;
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL bubble_drain_count got %0d want 0", a_count); end
        nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL bubble_drain_mvalid got %b want 0", a_m_valid); end
    endtask

    task automatic test_flush;
        a_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = 32'hF100_0000 + 32'(i);
            tick();
        end
        flush    = 1'b1;
        a_s_data = 32'hDEAD_BEEF;
        #1;
        nvec++; if (a_s_ready !== 1'b0) begin nerr++; $display("FAIL flush_sready got %b want 0", a_s_ready); end
        nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL flush_mvalid got %b want 0", a_m_valid); end
        tick();
        flush     = 1'b0;
        a_s_valid = 1'b0;
        #1;
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL flush_count got %0d want 0", a_count); end
        for (int c = 0; c < 6; c++) begin
            nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL flush_ghost c=%0d got %b want 0 data %h", c, a_m_valid, a_m_data); end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        a_m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = 32'h5A5A_0000 + 32'(i);
            tick();
        end
        rst = 1'b1;
        #1;
        nvec++; if (a_s_ready !== 1'b0) begin nerr++; $display("FAIL rmid_sready got %b want 0", a_s_ready); end
        nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL rmid_mvalid got %b want 0", a_m_valid); end
        tick();
        nvec++; if (a_count !== 3'd0) begin nerr++; $display("FAIL rmid_count got %0d want 0", a_count); end
        nvec++; if (a_m_data !== 32'h0) begin nerr++; $display("FAIL rmid_mdata got %h want 0", a_m_data); end
        rst       = 1'b0;
        a_m_ready = 1'b1;
        a_s_data  = 32'h0BAD_F00D;
        #1;
        nvec++; if (a_s_ready !== 1'b1) begin nerr++; $display("FAIL rmid_rel_sready got %b want 1", a_s_ready); end
        nvec++; if (a_m_valid !== 1'b0) begin nerr++; $display("FAIL rmid_rel_mvalid got %b want 0", a_m_valid); end
        tick();
        a_s_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            nvec++; if (a_m_valid !== (c == 4)) begin nerr++; $display("FAIL rmid_lat_mvalid c=%0d got %b want %b", c, a_m_valid, c == 4); end
            if (c == 4) begin
                nvec++; if (a_m_data !== 32'h0BAD_F00D) begin nerr++; $display("FAIL rmid_lat_mdata got %h want 0badf00d", a_m_data); end
            end
            tick();
        end
    endtask

    task automatic test_depth1;
        logic [7:0] q[$];
        logic [7:0] nd;
        int  occ;
        bit  exp_sr, exp_mv, out;
        nd  = 8'h11;
        occ = 0;
        for (int c = 0; c < 20; c++) begin
            b_m_ready = (c % 2 == 0);
            b_s_valid = 1'b1;
            b_s_data  = nd;
            #1;
            exp_sr = (occ == 0) || b_m_ready;
            exp_mv = (occ == 1);
            out    = exp_mv && b_m_ready;
            nvec++; if (b_s_ready !== exp_sr) begin nerr++; $display("FAIL d1_sready c=%0d got %b want %b", c, b_s_ready, exp_sr); end
            nvec++; if (b_m_valid !== exp_mv) begin nerr++; $display("FAIL d1_mvalid c=%0d got %b want %b", c, b_m_valid, exp_mv); end
            nvec++; if (b_count !== 1'(occ)) begin nerr++; $display("FAIL d1_count c=%0d got %0d want %0d", c, b_count, occ); end
            if (out && q.size() > 0) begin
                nvec++; if (b_m_data !== q[0]) begin nerr++; $display("FAIL d1_mdata c=%0d got %h want %h", c, b_m_data, q[0]); end
                void'(q.pop_front());
            end
            if (exp_sr) begin
                q.push_back(nd);
                nd = nd + 8'd1;
            end
            occ = occ - int'(out) + int'(exp_sr);
            tick();
        end
        b_s_valid = 1'b0;
        b_m_ready = 1'b1;
        #1;
        nvec++; if (b_m_valid !== 1'b1) begin nerr++; $display("FAIL d1_tail_mvalid got %b want 1", b_m_valid); end
        if (q.size() > 0) begin
            nvec++; if (b_m_data !== q[0]) begin nerr++; $display("FAIL d1_tail_mdata got %h want %h", b_m_data, q[0]); end
        end
        tick();
        nvec++; if (b_m_valid !== 1'b0) begin nerr++; $display("FAIL d1_end_mvalid got %b want 0", b_m_valid); end
        nvec++; if (b_count !== 1'b0) begin nerr++; $display("FAIL d1_end_count got %0d want 0", b_count); end
        nvec++; if (nd !== 8'h1B) begin nerr++; $display("FAIL d1_accepts got %h want 1b", nd); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_mid();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
